unidade_controle: RTL and testbench

UNIDADE_CONTROLE -- requirements
Module: unidade_controle

---
 rtl/unidade_controle.sv | 135 +++++++++++++
 tb/tb_unidade_controle.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Fetch/decode/execute controller: fetches one instruction per visit to FETCH and decodes it into register-bank and ALU controls.
// Optional feature: define UNIDADE_CONTROLE_DESVIO_EN to enable the conditional jump opcode (5'b11110).
module unidade_controle #(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 4,
    parameter int bits_pc       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_valid,
    input  logic [bits_palavra-1:0]  inst_data,
    input  logic [3:0]               Flags_ZCSO,
    output logic                     inst_req,
    output logic [bits_pc-1:0]       pc,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [4:0]               controleOperacao,
    output logic                     Hab_Escrita,
    output logic                     en,
    output logic                     halted
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_JUMP = 5'b11110;
    localparam logic [4:0] OP_HALT = 5'b11111;

    state_t                  r_state;
    logic [bits_palavra-1:0] r_ir;
    logic [bits_pc-1:0]      r_pc;
    logic                    r_inst_req;
    logic                    r_en;
    logic                    r_hab_escrita;
    logic                    r_halted;

    logic [4:0]              w_op;
    logic                    w_exec_active;
    logic [bits_pc-1:0]      w_pc_inc;

    assign w_op     = r_ir[15:11];
    assign w_pc_inc = r_pc + bits_pc'(1);

`ifdef UNIDADE_CONTROLE_DESVIO_EN
    logic       w_flag;
    logic       w_jump_taken;
    logic [1:0] w_flag_idx;

    // IR[10:9] selects Z,C,S,O in that order, i.e. counting down from bit 3.
    assign w_flag_idx    = 2'd3 - r_ir[10:9];
    assign w_flag        = Flags_ZCSO[w_flag_idx];
    assign w_jump_taken  = (w_flag == r_ir[8]);
    assign w_exec_active = (w_op != OP_NOP);
`else
    logic w_unused_bits;

    assign w_unused_bits = ^{Flags_ZCSO, r_ir[2:0]};
    // Without jumps the jump opcode degrades to a NOP.
    assign w_exec_active = (w_op != OP_NOP) && (w_op != OP_JUMP);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ir          <= '0;
            r_pc          <= '0;
            r_inst_req    <= 1'b0;
            r_en          <= 1'b0;
            r_hab_escrita <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_en          <= 1'b0;
            r_hab_escrita <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state    <= FETCH;
                    r_inst_req <= 1'b1;
                end
                FETCH: begin
                    if (inst_valid) begin
                        r_ir       <= inst_data;
                        r_state    <= DECODE;
                        r_inst_req <= 1'b0;
                    end
                end
                DECODE: begin
                    if (w_op == OP_HALT) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
`ifdef UNIDADE_CONTROLE_DESVIO_EN
                    end else if (w_op == OP_JUMP) begin
                        r_pc       <= w_jump_taken ? bits_pc'(r_ir[7:0]) : w_pc_inc;
                        r_state    <= FETCH;
                        r_inst_req <= 1'b1;
`endif
                    end else begin
                        r_state       <= EXECUTE;
                        r_en          <= w_exec_active;
                        r_hab_escrita <= w_exec_active;
                    end
                end
                EXECUTE: begin
                    r_pc       <= w_pc_inc;
                    r_state    <= FETCH;
                    r_inst_req <= 1'b1;
                end
                HALT: begin
                    r_state    <= HALT;
                    r_halted   <= 1'b1;
                    r_inst_req <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_inst_req <= 1'b0;
                end
            endcase
        end
    end

    assign inst_req         = r_inst_req;
    assign pc               = r_pc;
    assign en               = r_en;
    assign Hab_Escrita      = r_hab_escrita;
    assign halted           = r_halted;
    assign Sel_SA           = end_registros'(r_ir[10:7]);
    assign Sel_SB           = end_registros'(r_ir[6:3]);
    assign controleOperacao = r_ir[15:11];

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle; jump checks follow UNIDADE_CONTROLE_DESVIO_EN.
module tb_unidade_controle;

    logic        clk;
    logic        reset;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [3:0]  Flags_ZCSO;
    logic        inst_req;
    logic [7:0]  pc;
    logic [3:0]  Sel_SA;
    logic [3:0]  Sel_SB;
    logic [4:0]  controleOperacao;
    logic        Hab_Escrita;
    logic        en;
    logic        halted;

    int          n_pass;
    int          n_total;
    logic [7:0]  exp_pc;

    unidade_controle dut (
        .clk              (clk),
        .reset            (reset),
        .inst_valid       (inst_valid),
        .inst_data        (inst_data),
        .Flags_ZCSO       (Flags_ZCSO),
        .inst_req         (inst_req),
        .pc               (pc),
        .Sel_SA           (Sel_SA),
        .Sel_SB           (Sel_SB),
        .controleOperacao (controleOperacao),
        .Hab_Escrita      (Hab_Escrita),
        .en               (en),
        .halted           (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge in FETCH; returns at the negedge of the DECODE cycle.
    task automatic do_fetch(input logic [15:0] d);
        int k;
        k = 0;
        while (inst_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (inst_req !== 1'b1) begin
            n_total++;
            $display("FAIL fetch_timeout inst_req=%b required 1", inst_req);
        end
        inst_valid = 1'b1;
        inst_data  = d;
        @(negedge clk);
        inst_valid = 1'b0;
        $display("fetch 0x%04h at pc=%0d", d, pc);
    endtask

    task automatic test_reset();
        reset = 1'b0; inst_valid = 1'b0; inst_data = 16'h0; Flags_ZCSO = 4'h0;
        repeat (3) @(negedge clk);
        n_total++; if (inst_req !== 1'b0) $display("FAIL rst_inst_req got %b want 0", inst_req); else n_pass++;
        n_total++; if (pc !== 8'h00) $display("FAIL rst_pc got %h want 00", pc); else n_pass++;
        n_total++; if ({en, Hab_Escrita, halted} !== 3'b000) $display("FAIL rst_ctl got %b want 000", {en, Hab_Escrita, halted}); else n_pass++;
        n_total++; if ({Sel_SA, Sel_SB, controleOperacao} !== 13'h0) $display("FAIL rst_decode got %h want 0", {Sel_SA, Sel_SB, controleOperacao}); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (inst_req !== 1'b0) $display("FAIL rel_idle_req got %b want 0", inst_req); else n_pass++;
        @(negedge clk);
        n_total++; if (inst_req !== 1'b1) $display("FAIL rel_first_req got %b want 1", inst_req); else n_pass++;
        exp_pc = 8'h00;
        $display("reset done");
    endtask

    task automatic test_idle_fetch();
        for (int i = 0; i < 5; i++) begin
            n_total++; if (inst_req !== 1'b1) $display("FAIL wait_req[%0d] got %b want 1", i, inst_req); else n_pass++;
            n_total++; if (pc !== 8'h00) $display("FAIL wait_pc[%0d] got %h want 00", i, pc); else n_pass++;
            n_total++; if ({en, Hab_Escrita} !== 2'b00) $display("FAIL wait_en[%0d] got %b want 00", i, {en, Hab_Escrita}); else n_pass++;
            @(negedge clk);
        end
        $display("fetch wait 5 cycles pc=%0d", pc);
    endtask

    task automatic test_alu();
        do_fetch(16'h0898);
        n_total++; if (controleOperacao !== 5'd1) $display("FAIL alu_op got %0d want 1", controleOperacao); else n_pass++;
        n_total++; if (Sel_SA !== 4'd1) $display("FAIL alu_sa got %0d want 1", Sel_SA); else n_pass++;
        n_total++; if (Sel_SB !== 4'd3) $display("FAIL alu_sb got %0d want 3", Sel_SB); else n_pass++;
        n_total++; if ({inst_req, en} !== 2'b00) $display("FAIL alu_decode got %b want 00", {inst_req, en}); else n_pass++;
        @(negedge clk);
        n_total++; if ({en, Hab_Escrita} !== 2'b11) $display("FAIL alu_exec got %b want 11", {en, Hab_Escrita}); else n_pass++;
        n_total++; if (pc !== exp_pc) $display("FAIL alu_exec_pc got %h want %h", pc, exp_pc); else n_pass++;
        @(negedge clk);
        exp_pc++;
        n_total++; if ({en, Hab_Escrita, inst_req} !== 3'b001) $display("FAIL alu_after got %b want 001", {en, Hab_Escrita, inst_req}); else n_pass++;
        n_total++; if (pc !== exp_pc) $display("FAIL alu_pc got %h want %h", pc, exp_pc); else n_pass++;
    endtask

    task automatic test_nop();
        do_fetch(16'h0000);
        @(negedge clk);
        n_total++; if ({en, Hab_Escrita} !== 2'b00) $display("FAIL nop_exec got %b want 00", {en, Hab_Escrita}); else n_pass++;
        @(negedge clk);
        exp_pc++;
        n_total++; if (pc !== exp_pc) $display("FAIL nop_pc got %h want %h", pc, exp_pc); else n_pass++;
    endtask

    task automatic test_jump();
`ifdef UNIDADE_CONTROLE_DESVIO_EN
        Flags_ZCSO = 4'b1000;
        do_fetch(16'hF142);
        @(negedge clk);
        n_total++; if (pc !== 8'h42) $display("FAIL jmp_taken_pc got %h want 42", pc); else n_pass++;
        n_total++; if ({en, Hab_Escrita, inst_req} !== 3'b001) $display("FAIL jmp_taken_ctl got %b want 001", {en, Hab_Escrita, inst_req}); else n_pass++;
        Flags_ZCSO = 4'b0000;
        do_fetch(16'hF142);
        @(negedge clk);
        n_total++; if (pc !== 8'h43) $display("FAIL jmp_not_pc got %h want 43", pc); else n_pass++;
        n_total++; if (en !== 1'b0) $display("FAIL jmp_not_en got %b want 0", en); else n_pass++;
        Flags_ZCSO = 4'b0100;
        do_fetch(16'hF342);
        @(negedge clk);
        n_total++; if (pc !== 8'h42) $display("FAIL jmp_c_pc got %h want 42", pc); else n_pass++;
        Flags_ZCSO = 4'b0000;
        exp_pc = 8'h42;
`else
        Flags_ZCSO = 4'b1000;
        do_fetch(16'hF142);
        n_total++; if (controleOperacao !== 5'h1E) $display("FAIL jnop_op got %h want 1e", controleOperacao); else n_pass++;
        @(negedge clk);
        n_total++; if ({en, Hab_Escrita} !== 2'b00) $display("FAIL jnop_exec got %b want 00", {en, Hab_Escrita}); else n_pass++;
        @(negedge clk);
        exp_pc++;
        n_total++; if (pc !== exp_pc) $display("FAIL jnop_pc got %h want %h", pc, exp_pc); else n_pass++;
        Flags_ZCSO = 4'b0000;
`endif
    endtask

    task automatic test_back_to_back();
        inst_valid = 1'b1;
        inst_data  = 16'h0898;
        @(negedge clk);
        inst_data = 16'hF800;
        n_total++; if (controleOperacao !== 5'd1) $display("FAIL b2b_decode_op got %0d want 1", controleOperacao); else n_pass++;
        @(negedge clk);
        inst_data = 16'h1000;
        n_total++; if ({en, controleOperacao} !== 6'b1_00001) $display("FAIL b2b_exec got %b want 100001", {en, controleOperacao}); else n_pass++;
        @(negedge clk);
        exp_pc++;
        n_total++; if (pc !== exp_pc) $display("FAIL b2b_pc1 got %h want %h", pc, exp_pc); else n_pass++;
        n_total++; if ({inst_req, controleOperacao} !== 6'b1_00001) $display("FAIL b2b_fetch got %b want 100001", {inst_req, controleOperacao}); else n_pass++;
        @(negedge clk);
        inst_valid = 1'b0;
        n_total++; if ({inst_req, controleOperacao} !== 6'b0_00010) $display("FAIL b2b_second got %b want 000010", {inst_req, controleOperacao}); else n_pass++;
        @(negedge clk);
        n_total++; if (en !== 1'b1) $display("FAIL b2b_exec2 got %b want 1", en); else n_pass++;
        @(negedge clk);
        exp_pc++;
        n_total++; if (pc !== exp_pc) $display("FAIL b2b_pc2 got %h want %h", pc, exp_pc); else n_pass++;
        $display("back-to-back done pc=%0d", pc);
    endtask

    task automatic test_wrap();
        while (exp_pc != 8'hFF) begin
            do_fetch(16'h0898);
            @(negedge clk);
            @(negedge clk);
            exp_pc++;
        end
        n_total++; if (pc !== 8'hFF) $display("FAIL wrap_pre got %h want ff", pc); else n_pass++;
        do_fetch(16'h0898);
        @(negedge clk);
        @(negedge clk);
        exp_pc++;
        n_total++; if (pc !== 8'h00) $display("FAIL wrap_pc got %h want 00", pc); else n_pass++;
    endtask

    task automatic test_halt();
        do_fetch(16'hF800);
        @(negedge clk);
        n_total++; if ({halted, inst_req, en, Hab_Escrita} !== 4'b1000) $display("FAIL halt_ctl got %b want 1000", {halted, inst_req, en, Hab_Escrita}); else n_pass++;
        n_total++; if (pc !== exp_pc) $display("FAIL halt_pc got %h want %h", pc, exp_pc); else n_pass++;
        inst_valid = 1'b1;
        inst_data  = 16'h0898;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++; if ({halted, inst_req, en} !== 3'b100) $display("FAIL halt_hold[%0d] got %b want 100", i, {halted, inst_req, en}); else n_pass++;
            n_total++; if (controleOperacao !== 5'h1F) $display("FAIL halt_ir[%0d] got %h want 1f", i, controleOperacao); else n_pass++;
        end
        inst_valid = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        do_fetch(16'h0898);
        @(negedge clk);
        n_total++; if (en !== 1'b1) $display("FAIL mid_exec_en got %b want 1", en); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if ({inst_req, en, Hab_Escrita, halted} !== 4'b0000) $display("FAIL async_ctl got %b want 0000", {inst_req, en, Hab_Escrita, halted}); else n_pass++;
        n_total++; if ({pc, Sel_SA, Sel_SB, controleOperacao} !== 21'h0) $display("FAIL async_data got %h want 0", {pc, Sel_SA, Sel_SB, controleOperacao}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++; if (inst_req !== 1'b0) $display("FAIL rerel_idle got %b want 0", inst_req); else n_pass++;
        @(negedge clk);
        n_total++; if ({inst_req, pc} !== 9'h100) $display("FAIL rerel_fetch got %h want 100", {inst_req, pc}); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_pc  = 8'h00;
        test_reset();
        test_idle_fetch();
        test_alu();
        test_nop();
        test_jump();
        test_back_to_back();
        test_wrap();
        test_halt();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
